// File: rtl/alu_issue.sv
// alu_issue -- single-entry issue register between decode and the ALU stage.
//
// Purpose:
//   Accepts one decoded instruction per cycle from upstream (valid/ready
//   handshake), translates opcode/funct3/funct7b5 into a 5-bit ALU operation
//   code, selects the A/B operands and holds them in a registered entry until
//   the ALU stage consumes them (ex_ready). Undecodable instructions still
//   occupy the entry but are tagged with illegal=1 and ALU_operation=00000.
//
// Optional feature (macro ALU_ISSUE_FWD_EN):
//   When defined, each register operand is taken from the EX/MEM writeback
//   candidate if it targets the same non-zero register, else from the MEM/WB
//   candidate, else from the register file (MEM has priority over WB).
//   When undefined, the forwarding ports exist but are ignored.
//
// Ports:
//   CLK            in   rising-edge clock
//   RSTa           in   asynchronous active-high reset
//   in_valid       in   upstream offers an instruction
//   in_ready       out  entry can accept this cycle (combinational)
//   opcode         in   [6:0] instruction opcode
//   funct3         in   [2:0] instruction funct3
//   funct7b5       in   bit 5 of funct7 (ADD/SUB select)
//   rs1_addr       in   [4:0] source register 1 index
//   rs2_addr       in   [4:0] source register 2 index
//   rs1_data       in   [tamanyo-1:0] register file read 1
//   rs2_data       in   [tamanyo-1:0] register file read 2
//   imm            in   [tamanyo-1:0] sign-extended immediate
//   mem_we         in   EX/MEM writeback enable
//   mem_rd         in   [4:0] EX/MEM destination register
//   mem_data       in   [tamanyo-1:0] EX/MEM writeback value
//   wb_we          in   MEM/WB writeback enable
//   wb_rd          in   [4:0] MEM/WB destination register
//   wb_data        in   [tamanyo-1:0] MEM/WB writeback value
//   flush          in   discard held and incoming instruction
//   ex_ready       in   ALU stage consumes the held entry this cycle
//   out_valid      out  held entry is valid
//   illegal        out  held entry could not be decoded
//   A, B           out  [tamanyo-1:0] registered ALU operands
//   ALU_operation  out  [4:0] registered ALU operation code

module alu_issue #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  input  logic [tamanyo-1:0] rs1_data,
  input  logic [tamanyo-1:0] rs2_data,
  input  logic [tamanyo-1:0] imm,
  input  logic               mem_we,
  input  logic [4:0]         mem_rd,
  input  logic [tamanyo-1:0] mem_data,
  input  logic               wb_we,
  input  logic [4:0]         wb_rd,
  input  logic [tamanyo-1:0] wb_data,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               out_valid,
  output logic               illegal,
  output logic [tamanyo-1:0] A,
  output logic [tamanyo-1:0] B,
  output logic [4:0]         ALU_operation
);

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_ADDR = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_BLT  = 5'b00110;
  localparam logic [4:0] ALU_BGE  = 5'b00111;
  localparam logic [4:0] ALU_XOR  = 5'b01001;
  localparam logic [4:0] ALU_BEQ  = 5'b01010;

  logic               r_outValid;
  logic               r_illegal;
  logic [tamanyo-1:0] r_a;
  logic [tamanyo-1:0] r_b;
  logic [4:0]         r_aluOp;

  logic               w_load;
  logic [4:0]         w_aluOp;
  logic               w_illegal;
  logic               w_useImm;
  logic [tamanyo-1:0] w_src1;
  logic [tamanyo-1:0] w_src2;
  logic [tamanyo-1:0] w_opB;

  // The entry can take a new instruction when empty or when its current
  // occupant leaves in the same cycle.
  assign in_ready = !r_outValid || ex_ready;
  assign w_load   = in_valid && in_ready && !flush;

  // Decode: translate the instruction fields into an ALU operation and decide
  // whether B comes from the immediate. Anything not recognised is flagged
  // illegal with a null operation but still travels down the pipe.
  always_comb begin
    w_aluOp   = ALU_NONE;
    w_illegal = 1'b0;
    w_useImm  = 1'b0;
    case (opcode)
      OPC_REG, OPC_IMM: begin
        w_useImm = (opcode == OPC_IMM);
        case (funct3)
          3'b000:  w_aluOp = (opcode == OPC_REG && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  w_aluOp = ALU_AND;
          3'b110:  w_aluOp = ALU_OR;
          3'b100:  w_aluOp = ALU_XOR;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  w_aluOp = ALU_BEQ;
          3'b100:  w_aluOp = ALU_BLT;
          3'b101:  w_aluOp = ALU_BGE;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        w_aluOp  = ALU_ADDR;
        w_useImm = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_aluOp = ALU_NONE;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  // Operand bypass: the younger EX/MEM result wins over MEM/WB, and register
  // x0 is never forwarded since it is hardwired to zero.
  always_comb begin
    w_src1 = rs1_data;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs1_addr)) begin
      w_src1 = mem_data;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) begin
      w_src1 = wb_data;
    end
    w_src2 = rs2_data;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs2_addr)) begin
      w_src2 = mem_data;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) begin
      w_src2 = wb_data;
    end
  end
`else
  // Without bypassing the register file values are used as-is; the
  // forwarding inputs are folded into a sink so they stay connected.
  logic w_unusedFwd;
  assign w_src1      = rs1_data;
  assign w_src2      = rs2_data;
  assign w_unusedFwd = ^{mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
                         rs1_addr, rs2_addr};
`endif

  // The immediate is never subject to forwarding.
  assign w_opB = w_useImm ? imm : w_src2;

  // Entry register. Flush only kills the valid bit; the data fields may keep
  // stale contents because nothing downstream looks at them while invalid.
  // While the entry is held without ex_ready, no field is written.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      r_outValid <= 1'b0;
      r_illegal  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_aluOp    <= ALU_NONE;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_illegal  <= w_illegal;
      r_a        <= w_src1;
      r_b        <= w_opB;
      r_aluOp    <= w_aluOp;
    end else if (ex_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid     = r_outValid;
  assign illegal       = r_illegal;
  assign A             = r_a;
  assign B             = r_b;
  assign ALU_operation = r_aluOp;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- self-checking bench for alu_issue.
//
// Purpose:
//   Directed scenarios (reset, ADD/SUB, hold/back-to-back, flush, forwarding,
//   illegal decode with asynchronous reset) plus a randomized run checked
//   against a table-driven behavioural model of the issue entry.
//   Honours macro ALU_ISSUE_FWD_EN in its expectations.

module tb_alu_issue;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RSTa;
  logic         in_valid;
  logic         in_ready;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         funct7b5;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [W-1:0] imm;
  logic         mem_we;
  logic [4:0]   mem_rd;
  logic [W-1:0] mem_data;
  logic         wb_we;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         flush;
  logic         ex_ready;
  logic         out_valid;
  logic         illegal;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [4:0]   ALU_operation;

  int passCount  = 0;
  int checkCount = 0;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  // Reference model of the held entry.
  bit           expValid;
  logic [4:0]   expOp;
  logic         expIllegal;
  logic [W-1:0] expA;
  logic [W-1:0] expB;

  // Decode table keyed by {opcode, funct3}: bits [4:0] op code, bit 5 = B from imm.
  int unsigned decodeMap[bit [9:0]];

  alu_issue #(.tamanyo(W)) dut (
    .CLK(CLK), .RSTa(RSTa), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .illegal(illegal),
    .A(A), .B(B), .ALU_operation(ALU_operation)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic initDecodeMap();
    bit [2:0] f3;
    decodeMap[{7'b0110011, 3'b000}] = 1;
    decodeMap[{7'b0110011, 3'b111}] = 4;
    decodeMap[{7'b0110011, 3'b110}] = 5;
    decodeMap[{7'b0110011, 3'b100}] = 9;
    decodeMap[{7'b0010011, 3'b000}] = 1 + 32;
    decodeMap[{7'b0010011, 3'b111}] = 4 + 32;
    decodeMap[{7'b0010011, 3'b110}] = 5 + 32;
    decodeMap[{7'b0010011, 3'b100}] = 9 + 32;
    decodeMap[{7'b1100011, 3'b000}] = 10;
    decodeMap[{7'b1100011, 3'b100}] = 6;
    decodeMap[{7'b1100011, 3'b101}] = 7;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      decodeMap[{7'b0000011, f3}] = 3 + 32;
      decodeMap[{7'b0100011, f3}] = 3 + 32;
    end
  endtask

  function automatic void refDecode(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic f7, output logic [4:0] op,
                                    output logic ill, output logic useImm);
    bit [9:0] key;
    int unsigned val;
    key = {opc, f3};
    if (decodeMap.exists(key)) begin
      val    = decodeMap[key];
      op     = 5'(val % 32);
      useImm = (val >= 32);
      ill    = 1'b0;
      if (opc == 7'b0110011 && f3 == 3'b000 && f7) op = 5'd2;
    end else begin
      op     = 5'd0;
      useImm = 1'b0;
      ill    = 1'b1;
    end
  endfunction

  // Value a register operand should carry given the current writeback candidates.
  function automatic logic [W-1:0] refOperand(input logic [4:0] addr,
                                              input logic [W-1:0] regVal);
    bit hitMem;
    bit hitWb;
    hitMem = FWD_ON && mem_we && (mem_rd != 0) && (mem_rd == addr);
    hitWb  = FWD_ON && wb_we && (wb_rd != 0) && (wb_rd == addr);
    if (hitMem) return mem_data;
    if (hitWb) return wb_data;
    return regVal;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic [4:0] op;
    logic ill;
    logic useImm;
    bit acceptNow;
    acceptNow = !expValid || ex_ready;
    if (flush) begin
      expValid = 0;
    end else if (in_valid && acceptNow) begin
      refDecode(opcode, funct3, funct7b5, op, ill, useImm);
      expValid   = 1;
      expOp      = op;
      expIllegal = ill;
      expA       = refOperand(rs1_addr, rs1_data);
      expB       = useImm ? imm : refOperand(rs2_addr, rs2_data);
    end else if (ex_ready) begin
      expValid = 0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] opc,
                               input logic [2:0] f3, input logic f7,
                               input logic [4:0] a1, input logic [W-1:0] d1,
                               input logic [4:0] a2, input logic [W-1:0] d2,
                               input logic [W-1:0] im);
    in_valid = v; opcode = opc; funct3 = f3; funct7b5 = f7;
    rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2; imm = im;
  endtask

  task automatic clearForwarding();
    mem_we = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Step to one time unit after the next rising edge, keeping the model in step.
  task automatic waitEdge();
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    RSTa = 1; flush = 0; ex_ready = 0;
    clearForwarding();
    applyStimulus(0, 7'd0, 3'd0, 0, 5'd0, '0, 5'd0, '0, '0);
    expValid = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (ALU_operation !== 5'd0) $display("[TB] FAIL reset_op: got %b want 00000", ALU_operation); else passCount++;
    checkCount++; if ({A, B, illegal} !== '0) $display("[TB] FAIL reset_data: got A=%h B=%h ill=%b want zeros", A, B, illegal); else passCount++;
    RSTa = 0;
    waitEdge();
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready); else passCount++;
  endtask

  task automatic test_add_sub();
    ex_ready = 1;
    applyStimulus(1, 7'b0110011, 3'b000, 1, 5'd1, 32'd10, 5'd2, 32'd3, 32'h55);
    #1;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL sub_ready: got %b want 1", in_ready); else passCount++;
    waitEdge();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL sub_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (ALU_operation !== 5'b00010) $display("[TB] FAIL sub_op: got %b want 00010", ALU_operation); else passCount++;
    checkCount++; if (A !== 32'd10 || B !== 32'd3) $display("[TB] FAIL sub_operands: got A=%0d B=%0d want A=10 B=3", A, B); else passCount++;
    funct7b5 = 0;
    waitEdge();
    checkCount++; if (ALU_operation !== 5'b00001) $display("[TB] FAIL add_op: got %b want 00001", ALU_operation); else passCount++;
    in_valid = 0;
    waitEdge();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL drain_valid: got %b want 0", out_valid); else passCount++;
  endtask

  task automatic test_back_to_back();
    ex_ready = 1;
    applyStimulus(1, 7'b0110011, 3'b000, 0, 5'd3, 32'h11, 5'd4, 32'h22, 32'h0);
    waitEdge();
    ex_ready = 0;
    applyStimulus(1, 7'b0010011, 3'b110, 0, 5'd7, 32'h77, 5'd8, 32'h88, 32'hFFFF_FFF0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL hold_ready[%0d]: got %b want 0", c, in_ready); else passCount++;
      waitEdge();
      checkCount++;
      if (out_valid !== 1'b1 || ALU_operation !== 5'b00001 || A !== 32'h11 || B !== 32'h22 || illegal !== 1'b0)
        $display("[TB] FAIL hold_entry[%0d]: got v=%b op=%b A=%h B=%h want v=1 op=00001 A=11 B=22", c, out_valid, ALU_operation, A, B);
      else passCount++;
    end
    ex_ready = 1;
    #1;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b want 1", in_ready); else passCount++;
    waitEdge();
    checkCount++;
    if (out_valid !== 1'b1 || ALU_operation !== 5'b00101 || A !== 32'h77 || B !== 32'hFFFF_FFF0)
      $display("[TB] FAIL release_entry: got v=%b op=%b A=%h B=%h want v=1 op=00101 A=77 B=fffffff0", out_valid, ALU_operation, A, B);
    else passCount++;
    in_valid = 0;
    waitEdge();
  endtask

  task automatic test_flush();
    ex_ready = 0;
    applyStimulus(1, 7'b1100011, 3'b100, 0, 5'd1, 32'h5, 5'd2, 32'h6, 32'h0);
    waitEdge();
    checkCount++; if (out_valid !== 1'b1 || ALU_operation !== 5'b00110) $display("[TB] FAIL preflush_entry: got v=%b op=%b want v=1 op=00110", out_valid, ALU_operation); else passCount++;
    flush = 1; ex_ready = 1;
    waitEdge();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b want 0", out_valid); else passCount++;
    flush = 0; in_valid = 0;
    waitEdge();
  endtask

  task automatic test_forwarding();
    logic [W-1:0] want;
    ex_ready = 1;
    mem_we = 1; mem_rd = 5'd5; mem_data = 32'hAA;
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'hBB;
    applyStimulus(1, 7'b0110011, 3'b000, 0, 5'd5, 32'h11, 5'd6, 32'h33, 32'h0);
    waitEdge();
    want = FWD_ON ? 32'hAA : 32'h11;
    checkCount++; if (A !== want) $display("[TB] FAIL fwd_mem_a: got %h want %h", A, want); else passCount++;
    checkCount++; if (B !== 32'h33) $display("[TB] FAIL fwd_mem_b: got %h want 33", B); else passCount++;
    mem_rd = 5'd9;
    waitEdge();
    want = FWD_ON ? 32'hBB : 32'h11;
    checkCount++; if (A !== want) $display("[TB] FAIL fwd_wb_a: got %h want %h", A, want); else passCount++;
    mem_rd = 5'd0; rs1_addr = 5'd0; rs1_data = 32'h44;
    waitEdge();
    checkCount++; if (A !== 32'h44) $display("[TB] FAIL fwd_x0_a: got %h want 44", A); else passCount++;
    mem_rd = 5'd6;
    applyStimulus(1, 7'b0010011, 3'b000, 0, 5'd1, 32'h1, 5'd6, 32'h33, 32'h1234);
    waitEdge();
    checkCount++; if (B !== 32'h1234) $display("[TB] FAIL fwd_imm_b: got %h want 1234", B); else passCount++;
    clearForwarding();
    in_valid = 0;
    waitEdge();
  endtask

  task automatic test_random();
    logic [6:0] opcList [5];
    opcList[0] = 7'b0110011; opcList[1] = 7'b0010011; opcList[2] = 7'b1100011;
    opcList[3] = 7'b0000011; opcList[4] = 7'b0100011;
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      opcode   = ($urandom_range(0, 5) == 5) ? 7'($urandom) : opcList[$urandom_range(0, 4)];
      funct3   = 3'($urandom); funct7b5 = 1'($urandom);
      rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      checkCount++; if (in_ready !== (!expValid || ex_ready)) $display("[TB] FAIL rand_ready[%0d]: got %b want %b", n, in_ready, (!expValid || ex_ready)); else passCount++;
      waitEdge();
      checkCount++; if (out_valid !== expValid) $display("[TB] FAIL rand_valid[%0d]: got %b want %b", n, out_valid, expValid); else passCount++;
      if (expValid) begin
        checkCount++;
        if (ALU_operation !== expOp || illegal !== expIllegal)
          $display("[TB] FAIL rand_decode[%0d]: got op=%b ill=%b want op=%b ill=%b", n, ALU_operation, illegal, expOp, expIllegal);
        else passCount++;
        if (!expIllegal) begin
          checkCount++;
          if (A !== expA || B !== expB)
            $display("[TB] FAIL rand_operands[%0d]: got A=%h B=%h want A=%h B=%h", n, A, B, expA, expB);
          else passCount++;
        end
      end
    end
    flush = 0; in_valid = 0; ex_ready = 1;
    clearForwarding();
    waitEdge();
  endtask

  task automatic test_illegal_async_reset();
    ex_ready = 1;
    applyStimulus(1, 7'b1111111, 3'b000, 0, 5'd1, 32'h9, 5'd2, 32'h8, 32'h0);
    waitEdge();
    checkCount++; if (out_valid !== 1'b1 || illegal !== 1'b1 || ALU_operation !== 5'd0) $display("[TB] FAIL illegal_entry: got v=%b ill=%b op=%b want v=1 ill=1 op=00000", out_valid, illegal, ALU_operation); else passCount++;
    in_valid = 0; ex_ready = 0;
    #2;
    RSTa = 1;
    #1;
    checkCount++; if (out_valid !== 1'b0 || illegal !== 1'b0) $display("[TB] FAIL async_reset_flags: got v=%b ill=%b want 0 0", out_valid, illegal); else passCount++;
    checkCount++; if ({A, B, ALU_operation} !== '0) $display("[TB] FAIL async_reset_data: got A=%h B=%h op=%b want zeros", A, B, ALU_operation); else passCount++;
    #1;
    RSTa = 0;
    expValid = 0;
    waitEdge();
    checkCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); else passCount++;
  endtask

  initial begin
    initDecodeMap();
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_flush();
    test_forwarding();
    test_random();
    test_illegal_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
